// File: rtl/andrewm_uart_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM encoding,
// parity-mode constants and a parameter legality check.
package andrewm_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

  function automatic bit params_legal(input int data_bits, input int clks_per_bit,
                                      input int fifo_depth, input int parity_en,
                                      input int parity_odd, input int stop_bits);
    bit ok;
    ok = (data_bits >= 5) && (data_bits <= 8);
    ok = ok && (clks_per_bit >= 2);
    ok = ok && (fifo_depth >= 2) && (fifo_depth <= 16);
    ok = ok && ((fifo_depth & (fifo_depth - 1)) == 0);
    ok = ok && (parity_en == 0 || parity_en == 1);
    ok = ok && (parity_odd == PAR_EVEN || parity_odd == PAR_ODD);
    ok = ok && (stop_bits >= 1) && (stop_bits <= 2);
    return ok;
  endfunction

endpackage

// File: rtl/andrewm_uart_tx_fifo_if.sv
// Write port and line/status signals of the buffered UART transmitter.
// The loader side uses the master modport, the transmitter the slave modport.
interface andrewm_uart_tx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic                 wr_valid;
  logic [DATA_BITS-1:0] wr_data;
  logic                 wr_ready;
  logic                 ovf_clr;
  logic                 tx;
  logic                 busy;
  logic [CW-1:0]        fifo_count;
  logic                 overflow;

  modport master (
    output wr_valid, wr_data, ovf_clr,
    input  wr_ready, tx, busy, fifo_count, overflow
  );

  modport slave (
    input  wr_valid, wr_data, ovf_clr,
    output wr_ready, tx, busy, fifo_count, overflow
  );
endinterface

// File: rtl/andrewm_sync_fifo.sv
// Single-clock FIFO with occupancy count; push when full and pop when empty
// are ignored. Storage is not reset, only the pointers and count.
module andrewm_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               din,
  output logic [WIDTH-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/andrewm_uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed serialiser producing start, data (LSB
// first), optional parity and 1-2 stop bits, with frames sent back-to-back.
module andrewm_uart_tx_fifo
  import andrewm_uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  andrewm_uart_tx_fifo_if.slave  bus
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX  = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);

  if (!params_legal(DATA_BITS, CLKS_PER_BIT, FIFO_DEPTH, PARITY_EN, PARITY_ODD, STOP_BITS)) begin : g_bad_params
    $error("andrewm_uart_tx_fifo: illegal parameter combination");
  end

  function automatic logic parity_of(input logic [DATA_BITS-1:0] w);
    return (^w) ^ (PARITY_ODD == PAR_ODD);
  endfunction

  tx_state_e            state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [2:0]           bitcnt_q, bitcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 ovf_q, ovf_d;
  logic                 pop, launch, baud_done;
  logic                 fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] head;
  logic [CW-1:0]        count;

  andrewm_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.wr_valid && !fifo_full),
    .pop   (pop),
    .din   (bus.wr_data),
    .dout  (head),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign baud_done = (baud_q == '0);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_done ? BAUD_MAX : baud_q - BW'(1);
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    tx_d     = tx_q;
    launch   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        baud_d = baud_q;
        launch = !fifo_empty;
      end
      ST_START: if (baud_done) begin
        state_d  = ST_DATA;
        tx_d     = shift_q[0];
        bitcnt_d = '0;
      end
      ST_DATA: if (baud_done) begin
        if (bitcnt_q == LAST_DATA) begin
          bitcnt_d = '0;
          if (PARITY_EN != 0) begin
            state_d = ST_PARITY;
            tx_d    = par_q;
          end else begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end
        end else begin
          shift_d  = shift_q >> 1;
          tx_d     = shift_q[1];
          bitcnt_d = bitcnt_q + 3'd1;
        end
      end
      ST_PARITY: if (baud_done) begin
        state_d = ST_STOP;
        tx_d    = 1'b1;
      end
      ST_STOP: if (baud_done) begin
        if (bitcnt_q == LAST_STOP) begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
          launch  = !fifo_empty;
        end else begin
          bitcnt_d = bitcnt_q + 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Next word is loaded straight into START so consecutive frames have no gap.
    pop = launch;
    if (launch) begin
      state_d = ST_START;
      shift_d = head;
      par_d   = parity_of(head);
      tx_d    = 1'b0;
      baud_d  = BAUD_MAX;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (bus.ovf_clr) ovf_d = 1'b0;
    if (bus.wr_valid && fifo_full) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bitcnt_q <= '0;
      tx_q     <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bitcnt_q <= bitcnt_d;
      tx_q     <= tx_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    par_q   <= par_d;
  end

  assign bus.wr_ready   = !fifo_full;
  assign bus.tx         = tx_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.fifo_count = count;
  assign bus.overflow   = ovf_q;
endmodule
